credit_store: RTL

// - Write side of the credit_return path. Accepts 16-bit packets on an AXI-Stream input and

---
 rtl/credit_pkg.sv | 12 +
 rtl/credit_pool.sv | 46 ++++
 rtl/credit_store.sv | 123 ++++++++++++
 3 files changed

// File: rtl/credit_pkg.sv
// credit_pkg: widths, FSM states and descriptor layout shared by credit_store and credit_return
package credit_pkg;
    localparam int SLOT_W = 8;
    localparam int WORD_W = 16;
    localparam int LINE_W = 256;
    localparam int WCNT_W = 4;
    typedef enum logic [1:0] {IDLE, DATA, DESC, SEND} store_state_t;
    typedef struct packed {
        logic [7:0] size;
        logic [7:0] line;
    } desc_t;
endpackage

// File: rtl/credit_pool.sv
// credit_pool: busy bitmap of slots with lowest-free allocation and checked release
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_alloc           mark o_slot busy at the next edge
//   i_free_valid/idx  release a slot; releasing a free or out-of-range slot is ignored
//   o_any_free        at least one slot is free
//   o_slot            lowest free slot index
//   o_err_free        registered 1-cycle pulse for an ignored release
module credit_pool
    import credit_pkg::*;
#(
    parameter int NUM_SLOTS = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_alloc,
    input  logic              i_free_valid,
    input  logic [SLOT_W-1:0] i_free_idx,
    output logic              o_any_free,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_err_free
);
    logic [NUM_SLOTS-1:0] r_busy, w_alloc_mask, w_free_mask;
    logic                 r_err_free;
    always_comb begin
        o_slot      = '0;
        w_free_mask = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_busy[i]) o_slot = SLOT_W'(i);
            w_free_mask[i] = i_free_valid && i_free_idx == SLOT_W'(i) && r_busy[i];
        end
        // ~b & (b+1) isolates the lowest zero bit, the same slot o_slot names
        w_alloc_mask = i_alloc ? ~r_busy & (r_busy + NUM_SLOTS'(1)) : '0;
        o_any_free   = ~&r_busy;
        o_err_free   = r_err_free;
    end
    // allocation uses the pre-free bitmap; both updates land on the same edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy     <= '0;
            r_err_free <= 1'b0;
        end else begin
            r_busy     <= (r_busy | w_alloc_mask) & ~w_free_mask;
            r_err_free <= i_free_valid && ~|w_free_mask;
        end
    end
endmodule

// File: rtl/credit_store.sv
// credit_store: stores AXI-Stream packets into a credit slot and emits the slot index
//   aclk, areset           clock, asynchronous active-high reset
//   in_t*                  16-bit packet words (in_tready high only while storing)
//   out_t*                 allocated slot index, held until out_tready
//   free_t*                slot index being returned (always accepted)
//   wr_a_*                 descriptor write {size, line} at address = slot
//   wr_b_*                 packet word write at {line, word}
//   err_trunc / err_free   1-cycle pulses: packet cut at MAX_WORDS / bad release
module credit_store
    import credit_pkg::*;
#(
    parameter int NUM_SLOTS = 16,
    parameter int LINE_BASE = 0,
    parameter int MAX_WORDS = LINE_W / WORD_W
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [WORD_W-1:0]        in_tdata,
    input  logic                     in_tvalid,
    input  logic                     in_tlast,
    output logic                     in_tready,
    output logic [SLOT_W-1:0]        out_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    input  logic [SLOT_W-1:0]        free_tdata,
    input  logic                     free_tvalid,
    output logic [SLOT_W-1:0]        wr_a_addr,
    output logic [15:0]              wr_a_data,
    output logic                     wr_a_valid,
    output logic [SLOT_W+WCNT_W-1:0] wr_b_addr,
    output logic [WORD_W-1:0]        wr_b_data,
    output logic                     wr_b_valid,
    output logic                     err_trunc,
    output logic                     err_free
);
    store_state_t              r_state, w_next;
    logic [SLOT_W-1:0]         r_slot, w_pool_slot, w_line;
    logic [WCNT_W:0]           r_wcnt;
    logic                      w_any_free, w_alloc, w_beat, w_end, w_trunc;
    logic [SLOT_W-1:0]         r_wr_a_addr;
    desc_t                     r_wr_a_data;
    logic                      r_wr_a_valid;
    logic [SLOT_W+WCNT_W-1:0]  r_wr_b_addr;
    logic [WORD_W-1:0]         r_wr_b_data;
    logic                      r_wr_b_valid;
    logic                      r_err_trunc;

    credit_pool #(.NUM_SLOTS(NUM_SLOTS)) u_pool (
        .i_clk        (aclk),
        .i_rst        (areset),
        .i_alloc      (w_alloc),
        .i_free_valid (free_tvalid),
        .i_free_idx   (free_tdata),
        .o_any_free   (w_any_free),
        .o_slot       (w_pool_slot),
        .o_err_free   (err_free)
    );

    assign w_line     = r_slot + SLOT_W'(LINE_BASE);
    assign wr_a_addr  = r_wr_a_addr;
    assign wr_a_data  = r_wr_a_data;
    assign wr_a_valid = r_wr_a_valid;
    assign wr_b_addr  = r_wr_b_addr;
    assign wr_b_data  = r_wr_b_data;
    assign wr_b_valid = r_wr_b_valid;
    assign err_trunc  = r_err_trunc;

    always_comb begin
        in_tready  = r_state == DATA;
        out_tvalid = r_state == SEND;
        out_tdata  = out_tvalid ? r_slot : '0;
        w_alloc    = r_state == IDLE && in_tvalid && w_any_free;
        w_beat     = in_tready && in_tvalid;
        w_trunc    = w_beat && !in_tlast && r_wcnt == (WCNT_W+1)'(MAX_WORDS - 1);
        w_end      = w_beat && (in_tlast || w_trunc);
        w_next     = r_state;
        case (r_state)
            IDLE:    w_next = w_alloc ? DATA : IDLE;
            DATA:    w_next = w_end ? DESC : DATA;
            DESC:    w_next = SEND;
            SEND:    w_next = out_tready ? IDLE : SEND;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // descriptor is registered on the final beat so it is written during DESC,
    // alongside the last word, one cycle before out_tvalid rises
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_slot       <= '0;
            r_wcnt       <= '0;
            r_wr_a_addr  <= '0;
            r_wr_a_data  <= '0;
            r_wr_a_valid <= 1'b0;
            r_wr_b_addr  <= '0;
            r_wr_b_data  <= '0;
            r_wr_b_valid <= 1'b0;
            r_err_trunc  <= 1'b0;
        end else begin
            r_wr_b_valid <= w_beat;
            r_wr_a_valid <= w_end;
            r_err_trunc  <= w_trunc;
            if (w_alloc) begin
                r_slot <= w_pool_slot;
                r_wcnt <= '0;
            end
            if (w_beat) begin
                r_wr_b_addr <= {w_line, r_wcnt[WCNT_W-1:0]};
                r_wr_b_data <= in_tdata;
                r_wcnt      <= r_wcnt + (WCNT_W+1)'(1);
            end
            if (w_end) begin
                r_wr_a_addr <= r_slot;
                r_wr_a_data <= '{size: 8'(r_wcnt) + 8'd1, line: w_line};
            end
        end
    end
endmodule
